// File: rtl/lu_pkg.sv
// Shared constants and state encoding for the LU band collector.
package lu_pkg;

    localparam int LU_N  = 8;
    localparam int LU_W  = 8;
    localparam int LU_BW = 3;
    localparam int LU_IW = $clog2(LU_N);
    localparam int LU_DW = $clog2(LU_BW + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DRAIN,
        S_DONE
    } lu_state_e;

endpackage

// File: rtl/lu_band_store.sv
// Band storage for L (strictly below diagonal, BW diagonals) and U (diagonal plus BW above).
// Storage is indexed [row][diagonal offset]. Reads return the dense-matrix value at (row, col).
module lu_band_store
    import lu_pkg::*;
#(
    parameter int N  = LU_N,
    parameter int W  = LU_W,
    parameter int IW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LU_BW:0]   u_we_i,
    input  logic [IW-1:0]    u_row_i [LU_BW+1],
    input  logic [W-1:0]     u_dat_i [LU_BW+1],
    input  logic [LU_BW-1:0] l_we_i,
    input  logic [IW-1:0]    l_row_i [LU_BW],
    input  logic [W-1:0]     l_dat_i [LU_BW],
    input  logic             rd_sel_i,
    input  logic [IW-1:0]    rd_row_i,
    input  logic [IW-1:0]    rd_col_i,
    output logic [W-1:0]     rd_data_o
);

    // u_q[i][d] holds U[i][i+d]; l_q[i][d] holds L[i][i-d-1]
    logic [W-1:0] u_q [N][LU_BW+1];
    logic [W-1:0] l_q [N][LU_BW];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                for (int d = 0; d <= LU_BW; d++) u_q[i][d] <= '0;
                for (int d = 0; d < LU_BW; d++)  l_q[i][d] <= '0;
            end
        end else begin
            for (int d = 0; d <= LU_BW; d++)
                if (u_we_i[d]) u_q[u_row_i[d]][d] <= u_dat_i[d];
            for (int d = 0; d < LU_BW; d++)
                if (l_we_i[d]) l_q[l_row_i[d]][d] <= l_dat_i[d];
        end
    end

    always_comb begin
        rd_data_o = '0;
        if (!rd_sel_i) begin
            if (rd_row_i == rd_col_i) rd_data_o = W'(1);
            for (int d = 1; d <= LU_BW; d++)
                if (rd_row_i > rd_col_i && (rd_row_i - rd_col_i) == IW'(d))
                    rd_data_o = l_q[rd_row_i][d-1];
        end else begin
            for (int d = 0; d <= LU_BW; d++)
                if (rd_col_i >= rd_row_i && (rd_col_i - rd_row_i) == IW'(d))
                    rd_data_o = u_q[rd_row_i][d];
        end
    end

endmodule

// File: rtl/lu_band_collector.sv
// Captures skewed luFactorizer L/U lanes into band storage and replays dense L then U row-major.
// Optional zero-pivot flag enabled by defining LU_ZERO_PIVOT_CHK_EN.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_CAPTURE | sampling lanes, offsets 1..3(N-1) (offset 0 is the start cycle)
// S_DRAIN   | streaming 2*N*N beats over valid/ready
// S_DONE    | drain complete, waiting for restart
module lu_band_collector
    import lu_pkg::*;
#(
    parameter int N = LU_N,
    parameter int W = LU_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [W-1:0]         lL1,
    input  logic [W-1:0]         lL2,
    input  logic [W-1:0]         lL3,
    input  logic [W-1:0]         uL1,
    input  logic [W-1:0]         uL2,
    input  logic [W-1:0]         uL3,
    input  logic [W-1:0]         uL4,
    output logic                 busy,
    output logic                 done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sel,
    output logic [$clog2(N)-1:0] out_row,
    output logic [$clog2(N)-1:0] out_col,
    output logic [W-1:0]         out_data,
    output logic                 pivot_zero
);

    localparam int IW = $clog2(N);

    lu_state_e     state_q, state_d;
    logic [IW-1:0] r_q, r_d;
    logic [1:0]    p_q, p_d;
    logic          sel_q, sel_d;
    logic [IW-1:0] row_q, row_d;
    logic [IW-1:0] col_q, col_d;
    logic          valid_q, valid_d;

    logic          starting, cap_en, cap_last, fire, last_beat;
    logic [LU_BW:0]   u_we;
    logic [IW-1:0]    u_row [LU_BW+1];
    logic [W-1:0]     u_dat [LU_BW+1];
    logic [LU_BW-1:0] l_we;
    logic [IW-1:0]    l_row [LU_BW];
    logic [W-1:0]     l_dat [LU_BW];
    logic [W-1:0]     rd_data;

    // Row/phase counters sit at zero outside capture, so the start cycle is offset 0.
    assign starting  = start && (state_q == S_IDLE || state_q == S_DONE);
    assign cap_en    = starting || state_q == S_CAPTURE;
    assign cap_last  = state_q == S_CAPTURE && r_q == IW'(N-1) && p_q == 2'd0;
    assign fire      = valid_q && out_ready;
    assign last_beat = sel_q && row_q == IW'(N-1) && col_q == IW'(N-1);

    assign u_dat = '{uL1, uL2, uL3, uL4};
    assign l_dat = '{lL3, lL2, lL1};

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        p_d     = p_q;
        sel_d   = sel_q;
        row_d   = row_q;
        col_d   = col_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_CAPTURE;
                    p_d     = 2'd1;
                end
            end
            S_CAPTURE: begin
                if (cap_last) begin
                    state_d = S_DRAIN;
                    r_d     = '0;
                    p_d     = 2'd0;
                end else if (p_q == 2'd2) begin
                    p_d = 2'd0;
                    r_d = r_q + IW'(1);
                end else begin
                    p_d = p_q + 2'd1;
                end
            end
            S_DRAIN: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                end else if (fire) begin
                    if (last_beat) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        sel_d   = 1'b0;
                        row_d   = '0;
                        col_d   = '0;
                    end else if (col_q == IW'(N-1)) begin
                        col_d = '0;
                        if (row_q == IW'(N-1)) begin
                            row_d = '0;
                            sel_d = 1'b1;
                        end else begin
                            row_d = row_q + IW'(1);
                        end
                    end else begin
                        col_d = col_q + IW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Lane-to-band write decode; entries falling past row/column N-1 are dropped.
    always_comb begin
        u_we  = '0;
        l_we  = '0;
        u_row = '{default: '0};
        l_row = '{default: '0};
        if (cap_en) begin
            case (p_q)
                2'd0: begin
                    u_we[0]  = 1'b1;
                    u_row[0] = r_q;
                    if (r_q != '0 && r_q < IW'(N-2)) begin
                        u_we[3]  = 1'b1;
                        u_row[3] = r_q - IW'(1);
                        l_we[2]  = 1'b1;
                        l_row[2] = r_q + IW'(2);
                    end
                end
                2'd1: begin
                    if (r_q < IW'(N-1)) begin
                        u_we[1]  = 1'b1;
                        u_row[1] = r_q;
                        l_we[0]  = 1'b1;
                        l_row[0] = r_q + IW'(1);
                    end
                end
                2'd2: begin
                    if (r_q < IW'(N-2)) begin
                        u_we[2]  = 1'b1;
                        u_row[2] = r_q;
                        l_we[1]  = 1'b1;
                        l_row[1] = r_q + IW'(2);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            p_q     <= 2'd0;
            sel_q   <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            p_q     <= p_d;
            sel_q   <= sel_d;
            row_q   <= row_d;
            col_q   <= col_d;
            valid_q <= valid_d;
        end
    end

    lu_band_store #(.N(N), .W(W), .IW(IW)) u_store (
        .clk       (clk),
        .rst       (rst),
        .u_we_i    (u_we),
        .u_row_i   (u_row),
        .u_dat_i   (u_dat),
        .l_we_i    (l_we),
        .l_row_i   (l_row),
        .l_dat_i   (l_dat),
        .rd_sel_i  (sel_q),
        .rd_row_i  (row_q),
        .rd_col_i  (col_q),
        .rd_data_o (rd_data)
    );

    assign busy      = state_q == S_CAPTURE || state_q == S_DRAIN;
    assign done      = state_q == S_DONE;
    assign out_valid = valid_q;
    assign out_sel   = sel_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_data  = valid_q ? rd_data : '0;

`ifdef LU_ZERO_PIVOT_CHK_EN
    logic piv_q;

    always_ff @(posedge clk) begin
        if (rst)
            piv_q <= 1'b0;
        else
            piv_q <= (piv_q && !starting) || (cap_en && p_q == 2'd0 && uL1 == '0);
    end

    assign pivot_zero = piv_q;
`else
    assign pivot_zero = 1'b0;
`endif

endmodule

// File: tb/tb_lu_band_collector.sv
// Directed bench for lu_band_collector: capture from a known banded L/U pair, then check every drained beat.
module tb_lu_band_collector;

    localparam int N = 8;
    localparam int W = 8;
`ifdef LU_ZERO_PIVOT_CHK_EN
    localparam bit PIV_EN = 1'b1;
`else
    localparam bit PIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, start, out_ready;
    logic [W-1:0] lL1, lL2, lL3, uL1, uL2, uL3, uL4;
    logic         busy, done, out_valid, out_sel, pivot_zero;
    logic [2:0]   out_row, out_col;
    logic [W-1:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;
    int zero_row = -1;

    always #5 clk = ~clk;

    lu_band_collector #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .lL1        (lL1),
        .lL2        (lL2),
        .lL3        (lL3),
        .uL1        (uL1),
        .uL2        (uL2),
        .uL3        (uL3),
        .uL4        (uL4),
        .busy       (busy),
        .done       (done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sel    (out_sel),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_data   (out_data),
        .pivot_zero (pivot_zero)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference matrices: U row i = 1, 2i+2, 2i+3, 2i+4 along the band; L column j = 3j+2, 3j+3, 3j+4.
    function automatic logic [7:0] u_val(input int i, input int j);
        if (j < i || j - i > 3 || i >= N || j >= N) return 8'd0;
        if (i == j) return (i == zero_row) ? 8'd0 : 8'd1;
        return 8'(2 * i + (j - i) + 1);
    endfunction

    function automatic logic [7:0] l_val(input int i, input int j);
        if (i == j) return 8'd1;
        if (i < j || i - j > 3 || i >= N || j >= N) return 8'd0;
        return 8'(3 * j + (i - j) + 1);
    endfunction

    function automatic logic [31:0] beat_exp(input int k);
        int s, i, j;
        logic [7:0] d;
        s = k / (N * N);
        i = (k % (N * N)) / N;
        j = k % N;
        d = (s == 1) ? u_val(i, j) : l_val(i, j);
        return (32'(s) << 16) | (32'(i) << 12) | (32'(j) << 8) | 32'(d);
    endfunction

    // Unused and out-of-range lane slots carry 0xFF so any stray write shows up in the drain.
    task automatic set_lanes(input int o);
        int r, p;
        r = o / 3;
        p = o % 3;
        {lL1, lL2, lL3, uL1, uL2, uL3, uL4} = {7{8'hFF}};
        case (p)
            0: begin
                uL1 = u_val(r, r);
                if (r >= 1 && r + 2 < N) begin
                    uL4 = u_val(r - 1, r + 2);
                    lL1 = l_val(r + 2, r - 1);
                end
            end
            1: if (r + 1 < N) begin
                uL2 = u_val(r, r + 1);
                lL3 = l_val(r + 1, r);
            end
            default: if (r + 2 < N) begin
                uL3 = u_val(r, r + 2);
                lL2 = l_val(r + 2, r);
            end
        endcase
    endtask

    task automatic do_capture(input bit zpiv);
        zero_row = zpiv ? 3 : -1;
        for (int o = 0; o <= 3 * (N - 1); o++) begin
            start = (o == 0);
            set_lanes(o);
            if (o >= 1) begin
                check_eq("cap_busy", busy, 1'b1);
                check_eq("cap_pivot", pivot_zero, PIV_EN && zpiv && o >= 10);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check_eq("drain_entry_busy", busy, 1'b1);
        check_eq("drain_entry_valid", out_valid, 1'b0);
        check_eq("drain_entry_done", done, 1'b0);
    endtask

    // mode 0: always ready, 1: ready toggles every 3 cycles, 2: random ready
    task automatic do_drain(input int mode, input int rst_beat, input bit poke_start);
        int k = 0;
        int cyc = 0;
        bit stopped = 1'b0;
        logic [31:0] got;
        while (k < 2 * N * N && cyc < 3000 && !stopped) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc / 3) % 2) == 0;
                default: out_ready = ($urandom_range(0, 1) == 1);
            endcase
            start = poke_start && cyc == 10;
            if (out_valid) begin
                got = {15'b0, out_sel, 1'b0, out_row, 1'b0, out_col, out_data};
                check_eq("beat", got, beat_exp(k));
                if (k == rst_beat) begin
                    rst = 1'b1;
                    stopped = 1'b1;
                end else if (out_ready) begin
                    k++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        if (cyc >= 3000) check_eq("drain_timeout", 32'd0, 32'd1);
        if (stopped) begin
            check_eq("rst_busy", busy, 1'b0);
            check_eq("rst_valid", out_valid, 1'b0);
            check_eq("rst_done", done, 1'b0);
            check_eq("rst_data", out_data, 8'd0);
            rst = 1'b0;
            @(posedge clk); #1;
            check_eq("idle_busy", busy, 1'b0);
        end else begin
            check_eq("beats_seen", k, 2 * N * N);
            check_eq("end_done", done, 1'b1);
            check_eq("end_busy", busy, 1'b0);
            check_eq("end_valid", out_valid, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        {lL1, lL2, lL3, uL1, uL2, uL3, uL4} = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", busy, 1'b0);
        check_eq("reset_done", done, 1'b0);
        check_eq("reset_valid", out_valid, 1'b0);
        check_eq("reset_fields", {out_sel, out_row, out_col, out_data}, 15'd0);
        check_eq("reset_pivot", pivot_zero, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_hold", busy, 1'b0);

        do_capture(1'b0);
        do_drain(0, -1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check_eq("done_hold", done, 1'b1);

        do_capture(1'b1);
        do_drain(1, -1, 1'b0);
        check_eq("pivot_at_done", pivot_zero, PIV_EN);

        do_capture(1'b0);
        do_drain(0, 40, 1'b0);

        do_capture(1'b0);
        do_drain(2, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
